// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one start/stop sequential multiplier among NREQ requesters.
// Optional WAIT-state timeout is compiled in when MULT_ARB_TIMEOUT_EN is defined.
module mult_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*DW-1:0] i_mltnd_val,
  input  logic [NREQ*DW-1:0] i_mlter_val,
  output logic [NREQ-1:0]    o_grant,
  output logic [NREQ-1:0]    o_done,
  output logic [2*DW-1:0]    o_product,
  output logic               o_timeout,
  output logic               o_busy,
  output logic               o_mul_start,
  output logic [DW-1:0]      o_mul_mltnd,
  output logic [DW-1:0]      o_mul_mlter,
  input  logic [2*DW-1:0]    i_mul_product,
  input  logic               i_mul_stop
);
  localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0] NreqW = (IW+1)'(NREQ);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [DW-1:0]   mltnd_q, mltnd_d, mlter_q, mlter_d;
  logic [2*DW-1:0] product_q, product_d;
  logic            stop_q, stop_rise;

  logic [IW:0]     cand, ptr_inc;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [DW-1:0]   sel_mltnd, sel_mlter;
  logic [NREQ-1:0] idx_oh;

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    cand     = '0;
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= NreqW) cand = cand - NreqW;
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!pick_vld && i_req[k] && (cand == (IW+1)'(k))) begin
          pick_vld = 1'b1;
          pick     = IW'(k);
        end
      end
    end
    ptr_inc = {1'b0, pick} + (IW+1)'(1);
    if (ptr_inc == NreqW) ptr_inc = '0;
  end

  always_comb begin
    sel_mltnd = '0;
    sel_mlter = '0;
    idx_oh    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick == IW'(k)) begin
        sel_mltnd = i_mltnd_val[k*DW +: DW];
        sel_mlter = i_mlter_val[k*DW +: DW];
      end
      idx_oh[k] = (idx_q == IW'(k));
    end
  end

  // Edge tracking runs in every state so a level left over from earlier work never completes.
  assign stop_rise = i_mul_stop & ~stop_q;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          expire;

  assign expire    = (cnt_q == CW'(TIMEOUT - 1));
  assign o_timeout = (state_q == StDone) & to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign o_timeout      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    mltnd_d   = mltnd_q;
    mlter_d   = mlter_q;
    product_d = product_q;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_d      = to_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          idx_d   = pick;
          ptr_d   = ptr_inc[IW-1:0];
          mltnd_d = sel_mltnd;
          mlter_d = sel_mlter;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StWait;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (stop_rise) begin
          product_d = i_mul_product;
          state_d   = StDone;
`ifdef MULT_ARB_TIMEOUT_EN
          to_d      = 1'b0;
        end else if (expire) begin
          product_d = '0;
          to_d      = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d     = cnt_q + CW'(1);
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      idx_q     <= '0;
      mltnd_q   <= '0;
      mlter_q   <= '0;
      product_q <= '0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      mltnd_q   <= mltnd_d;
      mlter_q   <= mlter_d;
      product_q <= product_d;
      stop_q    <= i_mul_stop;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
`endif

  assign o_busy      = (state_q != StIdle);
  assign o_mul_start = (state_q == StLaunch);
  assign o_grant     = o_mul_start ? idx_oh : '0;
  assign o_done      = (state_q == StDone) ? idx_oh : '0;
  assign o_product   = product_q;
  assign o_mul_mltnd = mltnd_q;
  assign o_mul_mlter = mlter_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: cycle-timing reference model, stub multiplier, directed + random runs.
// Timeout scenario is included when MULT_ARB_TIMEOUT_EN is defined.
module tb_mult_share_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned TIMEOUT = 64;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [NREQ-1:0]    i_req;
  logic [NREQ*DW-1:0] i_mltnd_val, i_mlter_val;
  logic [NREQ-1:0]    o_grant, o_done;
  logic [2*DW-1:0]    o_product;
  logic               o_timeout, o_busy, o_mul_start;
  logic [DW-1:0]      o_mul_mltnd, o_mul_mlter;
  logic [2*DW-1:0]    i_mul_product;
  logic               i_mul_stop;
  logic [DW-1:0]      op_a [NREQ];
  logic [DW-1:0]      op_b [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign i_mltnd_val[g*DW +: DW] = op_a[g];
    assign i_mlter_val[g*DW +: DW] = op_b[g];
  end

  mult_share_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_mltnd_val(i_mltnd_val), .i_mlter_val(i_mlter_val),
    .o_grant(o_grant), .o_done(o_done), .o_product(o_product), .o_timeout(o_timeout),
    .o_busy(o_busy), .o_mul_start(o_mul_start), .o_mul_mltnd(o_mul_mltnd),
    .o_mul_mlter(o_mul_mlter), .i_mul_product(i_mul_product), .i_mul_stop(i_mul_stop)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit drop_on_grant = 1'b1;

  int done_k[$], done_p[$], done_t[$], done_c[$], grant_k[$], grant_c[$];

  // Reference model: an operation is described by its request cycle and its done cycle.
  bit        m_busy, m_to, m_prev_stop;
  int        m_k, m_t0, m_done_at, m_ptr;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_prod;
  logic [NREQ-1:0] e_grant, e_done;
  logic [15:0] e_prod;
  logic [7:0]  e_a, e_b;
  bit          e_to, e_busy, e_start;

  // Stub multiplier: 0 = stop pulse, 1 = stop held high until the next start, 2 = never stops.
  int s_mode = 0, s_cnt = 0, s_lat = 0;
  bit s_rand_mode = 1'b0;
  logic [7:0] s_a, s_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_to = 0; m_prev_stop = 0; m_k = 0; m_t0 = -10; m_done_at = -1; m_ptr = 0;
    m_a = '0; m_b = '0; m_prod = '0;
    e_grant = '0; e_done = '0; e_prod = '0; e_a = '0; e_b = '0;
    e_to = 0; e_busy = 0; e_start = 0;
  endtask

  task automatic model_advance();
    bit rise;
    int rq;
    if (!i_rst) begin
      model_reset();
      return;
    end
    rise = i_mul_stop && !m_prev_stop;
    rq   = 32'(i_req);
    if (!m_busy) begin
      for (int d = 0; d < NREQ; d++) begin
        int k;
        k = (m_ptr + d) % NREQ;
        if (!m_busy && ((rq >> k) & 1) != 0) begin
          m_busy = 1; m_k = k; m_a = op_a[k]; m_b = op_b[k];
          m_ptr = (k + 1) % NREQ; m_t0 = cyc; m_done_at = -1; m_to = 0;
        end
      end
    end else if (m_done_at < 0) begin
      if (cyc >= m_t0 + 2) begin
        if (rise) begin
          m_done_at = cyc + 1; m_prod = i_mul_product; m_to = 0;
        end else if (ToEn && cyc == m_t0 + 1 + int'(TIMEOUT)) begin
          m_done_at = cyc + 1; m_prod = '0; m_to = 1;
        end
      end
    end else if (cyc == m_done_at) begin
      m_busy = 0;
    end
    m_prev_stop = i_mul_stop;
    e_busy  = m_busy;
    e_start = m_busy && (cyc + 1 == m_t0 + 1);
    e_grant = e_start ? NREQ'(1 << m_k) : '0;
    e_done  = (m_busy && m_done_at == cyc + 1) ? NREQ'(1 << m_k) : '0;
    e_to    = (e_done != 0) && m_to;
    e_prod  = m_prod; e_a = m_a; e_b = m_b;
  endtask

  task automatic compare_all();
    check("grant", 32'(o_grant), 32'(e_grant));
    check("done", 32'(o_done), 32'(e_done));
    check("product", 32'(o_product), 32'(e_prod));
    check("timeout", 32'(o_timeout), 32'(e_to));
    check("busy", 32'(o_busy), 32'(e_busy));
    check("mul_start", 32'(o_mul_start), 32'(e_start));
    check("mul_mltnd", 32'(o_mul_mltnd), 32'(e_a));
    check("mul_mlter", 32'(o_mul_mlter), 32'(e_b));
    if (o_grant != 0) begin grant_k.push_back(oh_idx(o_grant)); grant_c.push_back(cyc); end
    if (o_done != 0) begin
      done_k.push_back(oh_idx(o_done)); done_p.push_back(int'(o_product));
      done_t.push_back(int'(o_timeout)); done_c.push_back(cyc);
    end
  endtask

  task automatic stub_reset();
    s_cnt = 0; i_mul_stop = 1'b0; i_mul_product = '0;
  endtask

  task automatic stub_drive();
    int lat;
    if (!i_rst) begin
      stub_reset();
      return;
    end
    if (o_mul_start) begin
      if (s_rand_mode) s_mode = ($urandom_range(9) == 0 && ToEn) ? 2 : int'($urandom_range(1));
      lat = (s_lat > 0) ? s_lat : int'($urandom_range(1, 6));
      if (s_mode == 1 && lat < 2) lat = 2;
      s_a = o_mul_mltnd; s_b = o_mul_mlter; s_cnt = lat;
      if (s_mode == 0 && lat >= 2) i_mul_stop = 1'($urandom_range(1));
      else if (s_mode != 1) i_mul_stop = 1'b0;
      if (s_mode != 1) i_mul_product = 16'($urandom);
    end else if (s_cnt > 1) begin
      s_cnt--; i_mul_stop = 1'b0;
      if (s_mode != 1) i_mul_product = 16'($urandom);
    end else if (s_cnt == 1) begin
      s_cnt = 0;
      i_mul_stop = (s_mode != 2);
      if (s_mode != 2) i_mul_product = 16'(s_a) * 16'(s_b);
    end else if (s_mode != 1) begin
      i_mul_stop = 1'b0;
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge i_clk);
    #1;
    cyc++;
    compare_all();
    stub_drive();
    if (drop_on_grant) i_req = i_req & ~o_grant;
  endtask

  task automatic clear_logs();
    done_k.delete(); done_p.delete(); done_t.delete(); done_c.delete();
    grant_k.delete(); grant_c.delete();
  endtask

  task automatic do_reset();
    i_rst = 1'b0; i_req = '0;
    #1;
    check("rst_grant", 32'(o_grant), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_product", 32'(o_product), 0);
    check("rst_timeout", 32'(o_timeout), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_start", 32'(o_mul_start), 0);
    check("rst_mltnd", 32'(o_mul_mltnd), 0);
    check("rst_mlter", 32'(o_mul_mlter), 0);
    model_reset(); stub_reset();
    tick(); tick();
    i_rst = 1'b1;
    clear_logs();
  endtask

  task automatic wait_done(input string name, input int n, input int budget);
    int b = 0;
    while (done_k.size() < n && b < budget) begin tick(); b++; end
    check(name, 32'(done_k.size()), 32'(n));
  endtask

  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
    op_a[k] = a; op_b[k] = b;
  endtask

  initial begin
    int req_cyc;
    i_rst = 1'b1; i_req = '0;
    for (int k = 0; k < NREQ; k++) set_ops(k, 8'd0, 8'd0);
    stub_reset(); model_reset();
    #3;
    do_reset();

    // 1: single request, 120 x 10, stop rises 3 cycles after start.
    set_ops(0, 8'd120, 8'd10); s_lat = 3; i_req = 4'b0001; req_cyc = cyc;
    wait_done("t1_wait", 1, 40);
    if (grant_k.size() > 0 && done_k.size() > 0) begin
      check("t1_grant_lat", 32'(grant_c[0] - req_cyc), 1);
      check("t1_grant_idx", 32'(grant_k[0]), 0);
      check("t1_done_idx", 32'(done_k[0]), 0);
      check("t1_product", 32'(done_p[0]), 1200);
      check("t1_timeout", 32'(done_t[0]), 0);
      check("t1_done_lat", 32'(done_c[0] - req_cyc), 5);
    end

    // 2: three simultaneous requests from a fresh pointer.
    do_reset(); s_lat = 0;
    set_ops(0, 8'd20, 8'd12); set_ops(1, 8'd32, 8'd100); set_ops(2, 8'd255, 8'd255);
    i_req = 4'b0111;
    wait_done("t2_wait", 3, 100);
    if (done_k.size() == 3) begin
      check("t2_order0", 32'(done_k[0]), 0); check("t2_prod0", 32'(done_p[0]), 240);
      check("t2_order1", 32'(done_k[1]), 1); check("t2_prod1", 32'(done_p[1]), 3200);
      check("t2_order2", 32'(done_k[2]), 2); check("t2_prod2", 32'(done_p[2]), 65025);
    end

    // 3: pointer sits at 3 after serving requester 2.
    clear_logs();
    set_ops(0, 8'd3, 8'd4); set_ops(3, 8'd5, 8'd6); i_req = 4'b1001;
    wait_done("t3_wait", 2, 60);
    if (done_k.size() == 2) begin
      check("t3_first", 32'(done_k[0]), 3); check("t3_prod_first", 32'(done_p[0]), 30);
      check("t3_second", 32'(done_k[1]), 0); check("t3_prod_second", 32'(done_p[1]), 12);
    end

    // 4: asynchronous reset in the middle of WAIT.
    clear_logs();
    set_ops(0, 8'd120, 8'd10); s_lat = 10; i_req = 4'b0001;
    repeat (4) tick();
    check("t4_busy_before", 32'(o_busy), 1);
    check("t4_no_done_yet", 32'(done_k.size()), 0);
    #2;
    do_reset(); s_lat = 0;
    set_ops(1, 8'd7, 8'd9); i_req = 4'b0010;
    wait_done("t4_wait", 1, 40);
    if (done_k.size() == 1) begin
      check("t4_idx", 32'(done_k[0]), 1); check("t4_product", 32'(done_p[0]), 63);
    end

    // 5: stop held high across operations.
    clear_logs(); s_mode = 1;
    set_ops(1, 8'd11, 8'd13); set_ops(2, 8'd5, 8'd6); i_req = 4'b0110;
    wait_done("t5_wait_a", 2, 60);
    set_ops(2, 8'd200, 8'd2); i_req = 4'b0100;
    wait_done("t5_wait_b", 3, 40);
    repeat (20) tick();
    check("t5_done_count", 32'(done_k.size()), 3);
    if (done_k.size() == 3) begin
      check("t5_k0", 32'(done_k[0]), 2); check("t5_p0", 32'(done_p[0]), 30);
      check("t5_k1", 32'(done_k[1]), 1); check("t5_p1", 32'(done_p[1]), 143);
      check("t5_k2", 32'(done_k[2]), 2); check("t5_p2", 32'(done_p[2]), 400);
    end
    s_mode = 0;

`ifdef MULT_ARB_TIMEOUT_EN
    // 6: multiplier never completes.
    do_reset(); s_mode = 2;
    set_ops(0, 8'd3, 8'd4); i_req = 4'b0001;
    wait_done("t6_wait", 1, 120);
    if (done_k.size() == 1 && grant_c.size() > 0) begin
      check("t6_idx", 32'(done_k[0]), 0);
      check("t6_timeout", 32'(done_t[0]), 1);
      check("t6_product", 32'(done_p[0]), 0);
      check("t6_wait_len", 32'(done_c[0] - grant_c[0]), 32'(TIMEOUT + 1));
    end
    clear_logs(); s_mode = 0;
    set_ops(1, 8'd6, 8'd7); i_req = 4'b0010;
    wait_done("t6_next_wait", 1, 40);
    if (done_k.size() == 1) begin
      check("t6_next_product", 32'(done_p[0]), 42);
      check("t6_next_timeout", 32'(done_t[0]), 0);
    end
`endif

    // Random traffic against the model.
    drop_on_grant = 1'b0; s_rand_mode = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      logic [NREQ-1:0] r;
      tick();
      r = i_req;
      for (int k = 0; k < NREQ; k++) begin
        if (r[k] && o_grant[k]) begin
          r[k] = ($urandom_range(3) == 0);
          set_ops(k, 8'($urandom), 8'($urandom));
        end else if (r[k]) begin
          if ($urandom_range(29) == 0) r[k] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          r[k] = 1'b1;
          set_ops(k, 8'($urandom), 8'($urandom));
        end
      end
      i_req = r;
    end
    i_req = '0;
    for (int b = 0; b < 200 && m_busy; b++) tick();
    check("drain_idle", 32'(o_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
